// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer for the single-cycle RV32I core: owns the PC, steers the
// next-PC mux and sequences one instruction at a time from instruction memory.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Valid,
  input  logic [31:0] IMEM_Data,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  input  logic        Exec_Done,
  input  logic        Branch_Taken,
  output logic        PC_Sel,
  output logic [31:0] PC_4,
  input  logic [31:0] PC_IN,
  output logic [31:0] PC,
  input  logic        Halt,
  output logic        Fault,
  output logic [31:0] Instret,
  output logic [2:0]  fsm_state
);

  // Memory handshake: IMEM_Req stays high for every FETCH cycle and the word on
  // IMEM_Data is accepted in the first cycle IMEM_Valid is seen with IMEM_Req
  // high; IMEM_Valid outside FETCH carries no meaning and is ignored.
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instret_q;
  logic        misaligned;
  logic        retire;

  assign misaligned = (PC_IN[1:0] != 2'b00);
  assign retire     = (state == ST_EXEC) && Exec_Done && !misaligned;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:   state_next = Halt ? ST_HALTED : ST_FETCH;
      ST_FETCH:  if (IMEM_Valid) state_next = ST_EXEC;
      ST_EXEC: begin
        if (Exec_Done) begin
          if (misaligned) state_next = ST_FAULT;
          else            state_next = Halt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: if (!Halt) state_next = ST_FETCH;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_BOOT;
    endcase
  end

  always_comb begin
    IMEM_Req    = 1'b0;
    Instr_Valid = 1'b0;
    Fault       = 1'b0;
    PC_Sel      = 1'b0;
    case (state)
      ST_FETCH: IMEM_Req = 1'b1;
      ST_EXEC: begin
        Instr_Valid = 1'b1;
        PC_Sel      = Branch_Taken;
      end
      ST_FAULT: Fault = 1'b1;
      default: ;
    endcase
  end

  // A misaligned target never touches PC or Instret; the core parks in FAULT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q      <= RESET_VECTOR;
      instr_q   <= NOP;
      instret_q <= 32'd0;
    end else begin
      if ((state == ST_FETCH) && IMEM_Valid) instr_q <= IMEM_Data;
      if (retire) begin
        pc_q      <= PC_IN;
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign PC        = pc_q;
  assign IMEM_Addr = pc_q;
  assign PC_4      = pc_q + 32'd4;
  assign Instr     = instr_q;
  assign Instret   = instret_q;
  assign fsm_state = state;

endmodule
